// File: rtl/sib_pkg.sv
// Shared types and constants for the sample-in-ball sequencer slice.
package sib_pkg;

    localparam int unsigned MLDSA_Q_WIDTH      = 23;
    localparam int unsigned SIB_MEM_ADDRS_DFLT = 64;
    localparam int unsigned SIB_CLR_CYCLES     = SIB_MEM_ADDRS_DFLT / 2;

    typedef enum logic [2:0] {
        SIB_SEQ_IDLE,
        SIB_SEQ_CLEAR,
        SIB_SEQ_RUN,
        SIB_SEQ_DONE,
        SIB_SEQ_ERR
    } sib_seq_state_e;

endpackage

// File: rtl/sib_mem_clr.sv
// Zero-fill generator: walks both memory ports over the polynomial, one even/odd address pair per cycle.
module sib_mem_clr
    import sib_pkg::*;
#(
    parameter int unsigned CLR_CYCLES = SIB_CLR_CYCLES
) (
    input  logic                                    clk,
    input  logic                                    rst_b,
    input  logic                                    zeroize,
    input  logic                                    en,
    output logic                                    last_o,
    output logic [1:0][7:2]                         addr_o,
    output logic [1:0][3:0][MLDSA_Q_WIDTH-1:0]      wrdata_o
);

    localparam int unsigned CNT_W = $clog2(CLR_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLR_CYCLES - 1);

    logic [CNT_W-1:0] clr_cnt;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            clr_cnt <= '0;
        end else if (zeroize) begin
            clr_cnt <= '0;
        end else if (en) begin
            clr_cnt <= last_o ? '0 : clr_cnt + 1'b1;
        end
    end

    assign last_o      = en && (clr_cnt == CNT_MAX);
    assign addr_o[0]   = 6'({clr_cnt, 1'b0});
    assign addr_o[1]   = 6'({clr_cnt, 1'b1});
    assign wrdata_o    = '0;

endmodule

// File: rtl/sib_seq_ctrl.sv
// SIB operation sequencer: zero-fill, hand memory to the core, gate Keccak stream, report done.
// Optional RUN watchdog enabled by defining SIB_SEQ_TIMEOUT_EN.
module sib_seq_ctrl
    import sib_pkg::*;
#(
`ifdef SIB_SEQ_TIMEOUT_EN
    parameter int unsigned SIB_TIMEOUT_CYC  = 4096,
`endif
    parameter int unsigned SIB_NUM_SAMPLERS = 4,
    parameter int unsigned SIB_SAMPLE_W     = 8,
    parameter int unsigned SIB_MEM_ADDRS    = SIB_MEM_ADDRS_DFLT
) (
    input  logic                                        clk,
    input  logic                                        rst_b,
    input  logic                                        zeroize,
    input  logic                                        start_i,
    output logic                                        busy_o,
    output logic                                        done_o,
    output logic                                        err_o,
    input  logic                                        kc_valid_i,
    input  logic [SIB_NUM_SAMPLERS*SIB_SAMPLE_W-1:0]    kc_data_i,
    output logic                                        kc_hold_o,
    output logic                                        sib_valid_o,
    output logic [SIB_NUM_SAMPLERS*SIB_SAMPLE_W-1:0]    sib_data_o,
    input  logic                                        sib_hold_i,
    input  logic                                        sib_done_i,
    input  logic [1:0]                                  core_cs_i,
    input  logic [1:0]                                  core_we_i,
    input  logic [1:0][7:2]                             core_addr_i,
    input  logic [1:0][3:0][MLDSA_Q_WIDTH-1:0]          core_wrdata_i,
    output logic [1:0]                                  cs_o,
    output logic [1:0]                                  we_o,
    output logic [1:0][7:2]                             addr_o,
    output logic [1:0][3:0][MLDSA_Q_WIDTH-1:0]          wrdata_o
);

    sib_seq_state_e state;
    logic           clr_last;
    logic [1:0][7:2]                        clr_addr;
    logic [1:0][3:0][MLDSA_Q_WIDTH-1:0]     clr_wrdata;

`ifdef SIB_SEQ_TIMEOUT_EN
    localparam logic [11:0] WD_LIMIT = 12'(SIB_TIMEOUT_CYC - 1);
    logic [11:0] wd_cnt;
`endif

    sib_mem_clr #(
        .CLR_CYCLES (SIB_MEM_ADDRS / 2)
    ) u_mem_clr (
        .clk      (clk),
        .rst_b    (rst_b),
        .zeroize  (zeroize),
        .en       (state == SIB_SEQ_CLEAR),
        .last_o   (clr_last),
        .addr_o   (clr_addr),
        .wrdata_o (clr_wrdata)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state  <= SIB_SEQ_IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            err_o  <= 1'b0;
`ifdef SIB_SEQ_TIMEOUT_EN
            wd_cnt <= '0;
`endif
        end else if (zeroize) begin
            state  <= SIB_SEQ_IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            err_o  <= 1'b0;
`ifdef SIB_SEQ_TIMEOUT_EN
            wd_cnt <= '0;
`endif
        end else begin
            done_o <= 1'b0;
            case (state)
                SIB_SEQ_IDLE: begin
                    if (start_i) begin
                        state  <= SIB_SEQ_CLEAR;
                        busy_o <= 1'b1;
                    end
                end
                SIB_SEQ_CLEAR: begin
                    if (clr_last) begin
                        state <= SIB_SEQ_RUN;
`ifdef SIB_SEQ_TIMEOUT_EN
                        wd_cnt <= '0;
`endif
                    end
                end
                SIB_SEQ_RUN: begin
                    // A done pulse on the watchdog limit cycle still completes normally.
                    if (sib_done_i) begin
                        state  <= SIB_SEQ_DONE;
                        done_o <= 1'b1;
                    end
`ifdef SIB_SEQ_TIMEOUT_EN
                    else if (wd_cnt == WD_LIMIT) begin
                        state  <= SIB_SEQ_ERR;
                        err_o  <= 1'b1;
                        busy_o <= 1'b0;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                SIB_SEQ_DONE: begin
                    state  <= SIB_SEQ_IDLE;
                    busy_o <= 1'b0;
                end
                SIB_SEQ_ERR: begin
                    state <= SIB_SEQ_ERR;
                end
                default: begin
                    state  <= SIB_SEQ_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    assign sib_valid_o = (state == SIB_SEQ_RUN) && kc_valid_i;
    assign sib_data_o  = (state == SIB_SEQ_RUN) ? kc_data_i : '0;
    assign kc_hold_o   = (state == SIB_SEQ_RUN) ? sib_hold_i : 1'b1;

    // zeroize gates the memory port combinationally so nothing is written on the clearing cycle.
    always_comb begin
        cs_o     = '0;
        we_o     = '0;
        addr_o   = '0;
        wrdata_o = '0;
        if (!zeroize) begin
            case (state)
                SIB_SEQ_CLEAR: begin
                    cs_o     = 2'b11;
                    we_o     = 2'b11;
                    addr_o   = clr_addr;
                    wrdata_o = clr_wrdata;
                end
                SIB_SEQ_RUN: begin
                    cs_o     = core_cs_i;
                    we_o     = core_we_i;
                    addr_o   = core_addr_i;
                    wrdata_o = core_wrdata_i;
                end
                default: begin
                    cs_o = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sib_seq_ctrl.sv
// Directed bench for sib_seq_ctrl; watchdog scenario runs when SIB_SEQ_TIMEOUT_EN is defined.
module tb_sib_seq_ctrl;
    import sib_pkg::*;

    logic                               clk = 1'b0;
    logic                               rst_b;
    logic                               zeroize;
    logic                               start_i;
    logic                               busy_o;
    logic                               done_o;
    logic                               err_o;
    logic                               kc_valid_i;
    logic [31:0]                        kc_data_i;
    logic                               kc_hold_o;
    logic                               sib_valid_o;
    logic [31:0]                        sib_data_o;
    logic                               sib_hold_i;
    logic                               sib_done_i;
    logic [1:0]                         core_cs_i;
    logic [1:0]                         core_we_i;
    logic [1:0][7:2]                    core_addr_i;
    logic [1:0][3:0][MLDSA_Q_WIDTH-1:0] core_wrdata_i;
    logic [1:0]                         cs_o;
    logic [1:0]                         we_o;
    logic [1:0][7:2]                    addr_o;
    logic [1:0][3:0][MLDSA_Q_WIDTH-1:0] wrdata_o;

    int unsigned n_run  = 0;
    int unsigned n_fail = 0;

    sib_seq_ctrl #(
        .SIB_NUM_SAMPLERS (4),
        .SIB_SAMPLE_W     (8),
        .SIB_MEM_ADDRS    (64)
    ) dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .zeroize       (zeroize),
        .start_i       (start_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .kc_valid_i    (kc_valid_i),
        .kc_data_i     (kc_data_i),
        .kc_hold_o     (kc_hold_o),
        .sib_valid_o   (sib_valid_o),
        .sib_data_o    (sib_data_o),
        .sib_hold_i    (sib_hold_i),
        .sib_done_i    (sib_done_i),
        .core_cs_i     (core_cs_i),
        .core_we_i     (core_we_i),
        .core_addr_i   (core_addr_i),
        .core_wrdata_i (core_wrdata_i),
        .cs_o          (cs_o),
        .we_o          (we_o),
        .addr_o        (addr_o),
        .wrdata_o      (wrdata_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) step();
    endtask

    task automatic test_reset();
        rst_b         = 1'b0;
        zeroize       = 1'b0;
        start_i       = 1'b0;
        kc_valid_i    = 1'b1;
        kc_data_i     = 32'hA5C3_1E7F;
        sib_hold_i    = 1'b0;
        sib_done_i    = 1'b0;
        core_cs_i     = 2'b11;
        core_we_i     = 2'b11;
        core_addr_i   = {6'h2A, 6'h11};
        core_wrdata_i = '1;
        #12;
        n_run++;
        if ({busy_o, done_o, err_o, kc_hold_o, sib_valid_o} !== 5'b00010) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy/done/err/hold/valid=%b required 00010",
                     {busy_o, done_o, err_o, kc_hold_o, sib_valid_o});
        end
        n_run++;
        if (cs_o !== 2'b00 || we_o !== 2'b00 || addr_o !== '0 || wrdata_o !== '0 || sib_data_o !== '0) begin
            n_fail++;
            $display("FAIL reset_mem: cs=%b we=%b addr=%h data=%h required all zero", cs_o, we_o, addr_o, sib_data_o);
        end
        @(negedge clk);
        rst_b = 1'b1;
        step();
    endtask

    // start -> 32 CLEAR cycles -> RUN at cycle 33; then hold mirroring and core write passthrough.
    task automatic test_clear_and_run();
        logic [5:0] ea0;
        logic [5:0] ea1;
        int unsigned bad;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        bad = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            ea0 = 6'(2 * i);
            ea1 = 6'(2 * i + 1);
            n_run++;
            if (cs_o !== 2'b11 || we_o !== 2'b11 || addr_o[0] !== ea0 || addr_o[1] !== ea1 || wrdata_o !== '0) begin
                n_fail++;
                $display("FAIL clear_write[%0d]: cs=%b we=%b a0=%h a1=%h required cs=11 we=11 a0=%h a1=%h data=0",
                         i, cs_o, we_o, addr_o[0], addr_o[1], ea0, ea1);
            end
            if (kc_hold_o !== 1'b1 || sib_valid_o !== 1'b0 || busy_o !== 1'b1) bad++;
            step();
        end
        n_run++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL clear_gating: %0d cycles with hold!=1/valid!=0/busy!=1, required 0", bad);
        end
        n_run++;
        if (sib_valid_o !== 1'b1 || sib_data_o !== kc_data_i || cs_o !== 2'b11 || addr_o !== core_addr_i) begin
            n_fail++;
            $display("FAIL run_entry_c33: valid=%b cs=%b addr=%h required valid=1 cs=11 addr=%h",
                     sib_valid_o, cs_o, addr_o, core_addr_i);
        end
        for (int unsigned i = 0; i < 3; i++) begin
            sib_hold_i = (i != 1);
            #1;
            n_run++;
            if (kc_hold_o !== sib_hold_i) begin
                n_fail++;
                $display("FAIL run_hold[%0d]: kc_hold=%b required %b", i, kc_hold_o, sib_hold_i);
            end
            step();
        end
        sib_hold_i = 1'b0;
        core_cs_i   = 2'b10;
        core_we_i   = 2'b10;
        core_addr_i = {6'h15, 6'h03};
        core_wrdata_i[1] = {23'd7, 23'd6, 23'd5, 23'd4};
        #1;
        n_run++;
        if (addr_o[1] !== 6'h15 || we_o !== 2'b10 || cs_o !== 2'b10 || wrdata_o[1] !== core_wrdata_i[1]) begin
            n_fail++;
            $display("FAIL core_write: addr1=%h we=%b cs=%b required addr1=15 we=10 cs=10", addr_o[1], we_o, cs_o);
        end
        step();
    endtask

    // Expects to be entered in RUN.
    task automatic test_done();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        kc_data_i = 32'h1234_5678;
        sib_done_i = 1'b1;
        #1;
        n_run++;
        if (busy_o !== 1'b1 || done_o !== 1'b0 || sib_valid_o !== 1'b1 || sib_data_o !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL done_cycle_fwd: busy=%b done=%b valid=%b data=%h required 1 0 1 12345678",
                     busy_o, done_o, sib_valid_o, sib_data_o);
        end
        step();
        sib_done_i = 1'b0;
        n_run++;
        if (done_o !== 1'b1 || busy_o !== 1'b1 || cs_o !== 2'b00 || sib_valid_o !== 1'b0 || kc_hold_o !== 1'b1) begin
            n_fail++;
            $display("FAIL done_state: done=%b busy=%b cs=%b valid=%b hold=%b required 1 1 00 0 1",
                     done_o, busy_o, cs_o, sib_valid_o, kc_hold_o);
        end
        step();
        n_run++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL after_done: done=%b busy=%b required 0 0", done_o, busy_o);
        end
        sib_done_i = 1'b1;
        step();
        sib_done_i = 1'b0;
        step();
        n_run++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_done_ignored: done=%b busy=%b required 0 0", done_o, busy_o);
        end
    endtask

    task automatic test_zeroize();
        int unsigned seen_done;
        start_i = 1'b1;
        zeroize = 1'b1;
        step();
        start_i = 1'b0;
        zeroize = 1'b0;
        n_run++;
        if (busy_o !== 1'b0 || cs_o !== 2'b00) begin
            n_fail++;
            $display("FAIL start_vs_zeroize: busy=%b cs=%b required 0 00", busy_o, cs_o);
        end
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        steps(10);
        n_run++;
        if (addr_o[0] !== 6'd20 || cs_o !== 2'b11) begin
            n_fail++;
            $display("FAIL clear_c10: a0=%h cs=%b required 14 11", addr_o[0], cs_o);
        end
        zeroize = 1'b1;
        #1;
        n_run++;
        if (cs_o !== 2'b00 || we_o !== 2'b00) begin
            n_fail++;
            $display("FAIL zeroize_clear_mem: cs=%b we=%b required 00 00", cs_o, we_o);
        end
        step();
        zeroize = 1'b0;
        n_run++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || cs_o !== 2'b00) begin
            n_fail++;
            $display("FAIL zeroize_clear_idle: busy=%b done=%b cs=%b required 0 0 00", busy_o, done_o, cs_o);
        end
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        n_run++;
        if (addr_o[0] !== 6'd0 || addr_o[1] !== 6'd1 || cs_o !== 2'b11) begin
            n_fail++;
            $display("FAIL restart_cnt: a0=%h a1=%h cs=%b required 00 01 11", addr_o[0], addr_o[1], cs_o);
        end
        steps(32);
        n_run++;
        if (cs_o !== core_cs_i || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rerun_entry: cs=%b busy=%b required %b 1", cs_o, busy_o, core_cs_i);
        end
        zeroize = 1'b1;
        #1;
        n_run++;
        if (cs_o !== 2'b00) begin
            n_fail++;
            $display("FAIL zeroize_run_mem: cs=%b required 00", cs_o);
        end
        seen_done = 0;
        step();
        zeroize = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (done_o !== 1'b0) seen_done++;
            step();
        end
        n_run++;
        if (busy_o !== 1'b0 || seen_done != 0 || kc_hold_o !== 1'b1) begin
            n_fail++;
            $display("FAIL zeroize_run_idle: busy=%b done_cycles=%0d hold=%b required 0 0 1",
                     busy_o, seen_done, kc_hold_o);
        end
    endtask

    task automatic test_watchdog();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        steps(32);
`ifdef SIB_SEQ_TIMEOUT_EN
        steps(4095);
        n_run++;
        if (busy_o !== 1'b1 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_limit_cycle: busy=%b err=%b required 1 0", busy_o, err_o);
        end
        step();
        n_run++;
        if (err_o !== 1'b1 || busy_o !== 1'b0 || kc_hold_o !== 1'b1 || cs_o !== 2'b00) begin
            n_fail++;
            $display("FAIL wd_err: err=%b busy=%b hold=%b cs=%b required 1 0 1 00", err_o, busy_o, kc_hold_o, cs_o);
        end
        start_i = 1'b1;
        steps(5);
        start_i = 1'b0;
        n_run++;
        if (err_o !== 1'b1 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_sticky: err=%b busy=%b required 1 0", err_o, busy_o);
        end
        zeroize = 1'b1;
        step();
        zeroize = 1'b0;
        n_run++;
        if (err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_zeroize: err=%b required 0", err_o);
        end
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        steps(32 + 4095);
        sib_done_i = 1'b1;
        step();
        sib_done_i = 1'b0;
        n_run++;
        if (done_o !== 1'b1 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_done_wins: done=%b err=%b required 1 0", done_o, err_o);
        end
        step();
`else
        steps(4200);
        n_run++;
        if (err_o !== 1'b0 || busy_o !== 1'b1 || sib_valid_o !== kc_valid_i) begin
            n_fail++;
            $display("FAIL no_wd_long_run: err=%b busy=%b valid=%b required 0 1 %b", err_o, busy_o, sib_valid_o, kc_valid_i);
        end
        sib_done_i = 1'b1;
        step();
        sib_done_i = 1'b0;
        n_run++;
        if (done_o !== 1'b1 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL no_wd_done: done=%b err=%b required 1 0", done_o, err_o);
        end
        step();
`endif
    endtask

    initial begin
        test_reset();
        test_clear_and_run();
        test_done();
        test_zeroize();
        test_watchdog();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
